mips_alu: RTL and testbench
===========================

// Module: mips_alu
// PURPOSE
//   32-bit integer ALU for the MIPS-subset CPU datapath. Executes the R-type
//   arithmetic, logic and shift operations selected by the funct field, or an
//   immediate-class operation selected by the primary opcode. Produces the
//   result and sign/zero flags combinationally. Also keeps a registered copy
//   for downstream stages that sample on the clock.
// PARAMETERS
//   none (datapath width fixed at 32 bits)
// PORTS
//   clk           in   1   system clock; rising-edge
//   reset         in   1   asynchronous, active-high reset
//   a             in   32  operand A (rs); shifted operand for all shifts
//   b             in   32  operand B (rt, or extended immediate); b[4:0] = variable shift amount
//   sa            in   6   shamt for SLL/SRL/SRA; only sa[4:0] used
//   op            in   6   R-type funct code
//   op_immediate  in   6   primary opcode; 6'b000000 selects R-type decode via op
//   r             out  32  combinational result
//   zero          out  1   r == 0
//   positive      out  1   r != 0 and r[31] == 0
//   negative      out  1   r[31] == 1
//   r_q           out  32  r registered on clk
//   flags_q       out  3   {zero,positive,negative} registered on clk
// BEHAVIOUR
//   - Clock and reset: one clock, clk; reset is asynchronous and active-high.
//   - r, zero, positive and negative are purely combinational from the inputs.
//     They have zero latency and do not depend on clk or reset.
//   - r_q and flags_q update on every rising edge of clk with the current r and flags.
//   - While reset is high, r_q = 0 and flags_q = 3'b000, asserted immediately (asynchronous).
//   - If op_immediate == 6'b000000, r is selected by op:
//       100001 ADDU  a+b, mod 2^32, no overflow trap
//       100011 SUBU  a-b, mod 2^32
//       000000 SLL   a << sa[4:0]
//       000010 SRL   a >> sa[4:0], zero-fill
//       000011 SRA   a >>> sa[4:0], fills with a[31]
//       000100 SLLV  a << b[4:0]
//       000110 SRLV  a >> b[4:0], zero-fill
//       000111 SRAV  a >>> b[4:0], fills with a[31]
//       101011 SLTU  32'd1 if a < b (unsigned), else 32'd0
//       100100 AND   a & b
//       100101 OR    a | b
//       100110 XOR   a ^ b
//       any other funct: r = 0
//   - If op_immediate != 0, op is ignored and r is selected by op_immediate:
//       001001 ADDIU a+b
//       001011 SLTIU (a < b unsigned) ? 1 : 0
//       001100 ANDI  a & b
//       001101 ORI   a | b
//       001110 XORI  a ^ b
//       any other opcode: r = 0
//   - Operand b arrives already extended; the ALU does no immediate extension.
//   - Shift amount: only 5 bits are used, so sa[5] and b[31:5] are ignored.
//     A shift amount of 0 gives r = a.
//   - Flags are derived from r for every operation. Exactly one of zero,
//     positive and negative is 1. Carry-out is discarded, so
//     32'hFFFFFFFF + 1 gives r = 0 and zero = 1.
// TESTING
//   - a=8, b=15, sa=1, R-type:
//       ADDU -> 23, positive=1
//       SUBU -> 32'hFFFFFFF9, negative=1
//       SLTU -> 1
//       AND -> 8;  OR -> 15;  XOR -> 7
//       SLL -> 16;  SRL -> 4;  SLLV -> 32'h40000
//   - a=32'hFFFF, b=1, sa=15:
//       ADDU -> 32'h10000, positive
//       SUBU -> 32'hFFFE
//       SLTU -> 0
//       SRA -> 1;  SRAV -> 32'h7FFF
//       SLL -> 32'h7FFF8000
//   - a=32'h80000000, sa=4:
//       SRA -> 32'hF8000000;  SRL -> 32'h08000000
//     a=32'hFFFFFFFF, b=1:
//       ADDU -> 0, zero=1
//   - a=32'h3F5, b=0, op_immediate=001001:
//       r = 32'h3F5 for every op value in the table above
//     op_immediate=001100 -> r = 0
//   - Registered path:
//       assert reset mid-cycle -> r_q=0, flags_q=0 at once
//       release reset, ADDU a=8 b=15 -> r_q=23, flags_q=3'b010 after the next clk edge

Source files
------------

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - 32-bit MIPS-subset ALU with combinational result/flags and a registered copy
module mips_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [5:0]  sa,
   input  logic [5:0]  op,
   input  logic [5:0]  op_immediate,
   output logic [31:0] r,
   output logic        zero,
   output logic        positive,
   output logic        negative,
   output logic [31:0] r_q,
   output logic [2:0]  flags_q
);

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // Primary opcodes
   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDIU = 6'b001001;
   localparam logic [5:0] OPC_SLTIU = 6'b001011;
   localparam logic [5:0] OPC_ANDI  = 6'b001100;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_XORI  = 6'b001110;

   // Internal operation class after decoding both opcode spaces
   typedef enum logic [3:0] {
      ALU_ZERO,
      ALU_ADD,
      ALU_SUB,
      ALU_SLTU,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA
   } alu_fn_t;

   alu_fn_t     fn;
   logic        shift_var;
   logic        subtract;
   logic [31:0] b_eff;
   logic [32:0] sum;
   logic        a_lt_b;
   logic [4:0]  shamt;
   logic [31:0] sll_res;
   logic [31:0] srl_res;
   logic [31:0] sra_res;
   logic        sa_unused;

   // sa[5] is outside the 5-bit shift range and intentionally ignored
   assign sa_unused = sa[5];

   // Map funct (R-type) or primary opcode (immediate class) onto one operation
   always_comb begin
      fn        = ALU_ZERO;
      shift_var = 1'b0;
      if (op_immediate == OPC_RTYPE) begin
         case (op)
            FN_ADDU: fn = ALU_ADD;
            FN_SUBU: fn = ALU_SUB;
            FN_SLTU: fn = ALU_SLTU;
            FN_AND:  fn = ALU_AND;
            FN_OR:   fn = ALU_OR;
            FN_XOR:  fn = ALU_XOR;
            FN_SLL:  fn = ALU_SLL;
            FN_SRL:  fn = ALU_SRL;
            FN_SRA:  fn = ALU_SRA;
            FN_SLLV: begin
               fn        = ALU_SLL;
               shift_var = 1'b1;
            end
            FN_SRLV: begin
               fn        = ALU_SRL;
               shift_var = 1'b1;
            end
            FN_SRAV: begin
               fn        = ALU_SRA;
               shift_var = 1'b1;
            end
            default: fn = ALU_ZERO;
         endcase
      end else begin
         case (op_immediate)
            OPC_ADDIU: fn = ALU_ADD;
            OPC_SLTIU: fn = ALU_SLTU;
            OPC_ANDI:  fn = ALU_AND;
            OPC_ORI:   fn = ALU_OR;
            OPC_XORI:  fn = ALU_XOR;
            default:   fn = ALU_ZERO;
         endcase
      end
   end

   // One shared adder serves add, subtract and the unsigned compare.
   // With b inverted and carry-in set, carry-out high means a >= b.
   assign subtract = (fn == ALU_SUB) || (fn == ALU_SLTU);
   assign b_eff    = subtract ? ~b : b;
   assign sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, subtract};
   assign a_lt_b   = ~sum[32];

   // Shifts always move operand a; the amount comes from shamt or b[4:0]
   assign shamt   = shift_var ? b[4:0] : sa[4:0];
   assign sll_res = a << shamt;
   assign srl_res = a >> shamt;
   assign sra_res = 32'($signed(a) >>> shamt);

   // Result select; unknown encodings yield zero
   always_comb begin
      r = 32'd0;
      case (fn)
         ALU_ADD:  r = sum[31:0];
         ALU_SUB:  r = sum[31:0];
         ALU_SLTU: r = {31'd0, a_lt_b};
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = sll_res;
         ALU_SRL:  r = srl_res;
         ALU_SRA:  r = sra_res;
         default:  r = 32'd0;
      endcase
   end

   // Exactly one flag is set for any result
   assign zero     = (r == 32'd0);
   assign negative = r[31];
   assign positive = ~zero & ~r[31];

   // Registered copy of result and flags for clocked downstream stages
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q     <= 32'd0;
         flags_q <= 3'b000;
      end else begin
         r_q     <= r;
         flags_q <= {zero, positive, negative};
      end
   end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - randomized self-checking bench for mips_alu
module tb_mips_alu;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [5:0]  sa;
   logic [5:0]  op;
   logic [5:0]  op_immediate;
   logic [31:0] r;
   logic        zero;
   logic        positive;
   logic        negative;
   logic [31:0] r_q;
   logic [2:0]  flags_q;

   int passed;
   int total;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  sa;
      logic [5:0]  op;
      logic [5:0]  opi;
      logic [31:0] exp;
   } vec_t;

   mips_alu dut (
      .clk(clk),
      .reset(reset),
      .a(a),
      .b(b),
      .sa(sa),
      .op(op),
      .op_immediate(op_immediate),
      .r(r),
      .zero(zero),
      .positive(positive),
      .negative(negative),
      .r_q(r_q),
      .flags_q(flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Arithmetic right shift built from a logical shift plus a sign mask
   function automatic logic [31:0] sra_model(input logic [31:0] x, input int s);
      logic [31:0] res;
      logic [31:0] ones;
      ones = 32'hFFFFFFFF;
      res  = x >> s;
      if (x[31]) res = res | ~(ones >> s);
      return res;
   endfunction

   function automatic logic [31:0] model_r(input logic [31:0] xa, input logic [31:0] xb,
                                           input logic [5:0] xsa, input logic [5:0] xop,
                                           input logic [5:0] xopi);
      int s_fixed;
      int s_var;
      s_fixed = int'(xsa) % 32;
      s_var   = int'(xb % 32);
      if (xopi == 6'd0) begin
         case (xop)
            6'b100001: return xa + xb;
            6'b100011: return xa - xb;
            6'b000000: return xa << s_fixed;
            6'b000010: return xa >> s_fixed;
            6'b000011: return sra_model(xa, s_fixed);
            6'b000100: return xa << s_var;
            6'b000110: return xa >> s_var;
            6'b000111: return sra_model(xa, s_var);
            6'b101011: return (xa < xb) ? 32'd1 : 32'd0;
            6'b100100: return xa & xb;
            6'b100101: return xa | xb;
            6'b100110: return xa ^ xb;
            default:   return 32'd0;
         endcase
      end
      case (xopi)
         6'b001001: return xa + xb;
         6'b001011: return (xa < xb) ? 32'd1 : 32'd0;
         6'b001100: return xa & xb;
         6'b001101: return xa | xb;
         6'b001110: return xa ^ xb;
         default:   return 32'd0;
      endcase
   endfunction

   // {zero, positive, negative} from the sign/zero rules
   function automatic logic [2:0] model_flags(input logic [31:0] x);
      if (x == 32'd0) return 3'b100;
      if (x >= 32'h80000000) return 3'b001;
      return 3'b010;
   endfunction

   function automatic logic [5:0] pick_funct();
      case ($urandom_range(0, 12))
         0:  return 6'b100001;
         1:  return 6'b100011;
         2:  return 6'b000000;
         3:  return 6'b000010;
         4:  return 6'b000011;
         5:  return 6'b000100;
         6:  return 6'b000110;
         7:  return 6'b000111;
         8:  return 6'b101011;
         9:  return 6'b100100;
         10: return 6'b100101;
         11: return 6'b100110;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [5:0] pick_opcode();
      case ($urandom_range(0, 5))
         0: return 6'b001001;
         1: return 6'b001011;
         2: return 6'b001100;
         3: return 6'b001101;
         4: return 6'b001110;
         default: return 6'($urandom_range(1, 63));
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      reset        = 1'b1;
      a            = 32'd0;
      b            = 32'd0;
      sa           = 6'd0;
      op           = 6'd0;
      op_immediate = 6'd0;
      #1;
      total++;
      if (r_q !== 32'd0) $display("FAIL reset_r_q: got %h expected %h", r_q, 32'd0);
      else passed++;
      total++;
      if (flags_q !== 3'b000) $display("FAIL reset_flags_q: got %b expected %b", flags_q, 3'b000);
      else passed++;
   endtask

   task automatic test_spec_vectors();
      vec_t q[$];
      logic [5:0] all_ops[12];
      all_ops = '{6'b100001, 6'b100011, 6'b000000, 6'b000010, 6'b000011, 6'b000100,
                  6'b000110, 6'b000111, 6'b101011, 6'b100100, 6'b100101, 6'b100110};
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b100001, 6'd0, 32'd23});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b100011, 6'd0, 32'hFFFFFFF9});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b101011, 6'd0, 32'd1});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b100100, 6'd0, 32'd8});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b100101, 6'd0, 32'd15});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b100110, 6'd0, 32'd7});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b000000, 6'd0, 32'd16});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b000010, 6'd0, 32'd4});
      q.push_back('{32'd8, 32'd15, 6'd1, 6'b000100, 6'd0, 32'h40000});
      q.push_back('{32'hFFFF, 32'd1, 6'd15, 6'b100001, 6'd0, 32'h10000});
      q.push_back('{32'hFFFF, 32'd1, 6'd15, 6'b100011, 6'd0, 32'hFFFE});
      q.push_back('{32'hFFFF, 32'd1, 6'd15, 6'b101011, 6'd0, 32'd0});
      q.push_back('{32'hFFFF, 32'd1, 6'd15, 6'b000011, 6'd0, 32'd1});
      q.push_back('{32'hFFFF, 32'd1, 6'd15, 6'b000111, 6'd0, 32'h7FFF});
      q.push_back('{32'hFFFF, 32'd1, 6'd15, 6'b000000, 6'd0, 32'h7FFF8000});
      q.push_back('{32'h80000000, 32'd0, 6'd4, 6'b000011, 6'd0, 32'hF8000000});
      q.push_back('{32'h80000000, 32'd0, 6'd4, 6'b000010, 6'd0, 32'h08000000});
      q.push_back('{32'hFFFFFFFF, 32'd1, 6'd0, 6'b100001, 6'd0, 32'd0});
      foreach (all_ops[i]) q.push_back('{32'h3F5, 32'd0, 6'd0, all_ops[i], 6'b001001, 32'h3F5});
      q.push_back('{32'h3F5, 32'd0, 6'd0, 6'b100001, 6'b001100, 32'd0});
      // Shift amount boundaries: sa[5] and b[31:5] ignored, zero amount passes a through
      q.push_back('{32'h12345678, 32'd0, 6'b100000, 6'b000000, 6'd0, 32'h12345678});
      q.push_back('{32'h12345678, 32'd0, 6'b100011, 6'b000000, 6'd0, 32'h91A2B3C0});
      q.push_back('{32'h12345678, 32'hFFFFFFE0, 6'd0, 6'b000100, 6'd0, 32'h12345678});
      q.push_back('{32'h80000000, 32'hFFFFFFFF, 6'd0, 6'b000111, 6'd0, 32'hFFFFFFFF});
      q.push_back('{32'h80000000, 32'hFFFFFFFF, 6'd0, 6'b000110, 6'd0, 32'd1});
      q.push_back('{32'h12345678, 32'd5, 6'd7, 6'b111111, 6'd0, 32'd0});
      foreach (q[i]) begin
         a            = q[i].a;
         b            = q[i].b;
         sa           = q[i].sa;
         op           = q[i].op;
         op_immediate = q[i].opi;
         #1;
         total++;
         if (r !== q[i].exp)
            $display("FAIL spec_vec%0d_r: got %h expected %h", i, r, q[i].exp);
         else passed++;
         total++;
         if ({zero, positive, negative} !== model_flags(q[i].exp))
            $display("FAIL spec_vec%0d_flags: got %b expected %b", i,
                     {zero, positive, negative}, model_flags(q[i].exp));
         else passed++;
      end
   endtask

   task automatic test_random_rtype();
      logic [31:0] er;
      for (int i = 0; i < 300; i++) begin
         a            = pick_operand();
         b            = pick_operand();
         sa           = 6'($urandom);
         op           = pick_funct();
         op_immediate = 6'd0;
         #1;
         er = model_r(a, b, sa, op, op_immediate);
         total++;
         if (r !== er || {zero, positive, negative} !== model_flags(er))
            $display("FAIL rtype_rand: op=%b a=%h b=%h sa=%0d got %h/%b expected %h/%b",
                     op, a, b, sa, r, {zero, positive, negative}, er, model_flags(er));
         else passed++;
      end
   endtask

   task automatic test_random_immediate();
      logic [31:0] er;
      for (int i = 0; i < 200; i++) begin
         a            = pick_operand();
         b            = pick_operand();
         sa           = 6'($urandom);
         op           = 6'($urandom);
         op_immediate = pick_opcode();
         #1;
         er = model_r(a, b, sa, op, op_immediate);
         total++;
         if (r !== er || {zero, positive, negative} !== model_flags(er))
            $display("FAIL imm_rand: opi=%b a=%h b=%h got %h/%b expected %h/%b",
                     op_immediate, a, b, r, {zero, positive, negative}, er, model_flags(er));
         else passed++;
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      reset        = 1'b0;
      a            = 32'd8;
      b            = 32'd15;
      sa           = 6'd0;
      op           = 6'b100001;
      op_immediate = 6'd0;
      @(posedge clk);
      #1;
      total++;
      if (r_q !== 32'd23) $display("FAIL reg_addu_r_q: got %h expected %h", r_q, 32'd23);
      else passed++;
      total++;
      if (flags_q !== 3'b010) $display("FAIL reg_addu_flags_q: got %b expected %b", flags_q, 3'b010);
      else passed++;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (r_q !== 32'd0 || flags_q !== 3'b000)
         $display("FAIL reg_async_reset: got %h/%b expected %h/%b", r_q, flags_q, 32'd0, 3'b000);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (r_q !== 32'd0 || flags_q !== 3'b000)
         $display("FAIL reg_reset_hold: got %h/%b expected %h/%b", r_q, flags_q, 32'd0, 3'b000);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] er;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         a            = pick_operand();
         b            = pick_operand();
         sa           = 6'($urandom);
         op           = pick_funct();
         op_immediate = ($urandom_range(0, 2) == 0) ? pick_opcode() : 6'd0;
         er = model_r(a, b, sa, op, op_immediate);
         @(posedge clk);
         #1;
         total++;
         if (r_q !== er || flags_q !== model_flags(er))
            $display("FAIL back_to_back%0d: got %h/%b expected %h/%b",
                     i, r_q, flags_q, er, model_flags(er));
         else passed++;
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_spec_vectors();
      test_random_rtype();
      test_random_immediate();
      test_registered();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
